// File: rtl/spi_disp_pkg.sv
// spi_disp_pkg: state encoding and SPI constants for the display transmitter
package spi_disp_pkg;
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        LOW   = 3'd2,
        HIGH  = 3'd3,
        HOLD  = 3'd4,
        GAP   = 3'd5,
        DONE  = 3'd6
    } state_t;
    localparam logic SCLK_IDLE = 1'b1;
    localparam int BYTE_BITS = 8;
endpackage

// File: rtl/spi_phase_timer.sv
// spi_phase_timer: loadable down-counter whose strobe is high once it reaches zero
module spi_phase_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (cnt != '0) cnt <= cnt - 1'b1;
    end
    assign tc = cnt == '0;
endmodule

// File: rtl/spi_disp_tx.sv
// spi_disp_tx: mode-3 byte transmitter with a post-frame gap before requesting the next byte
module spi_disp_tx
    import spi_disp_pkg::*;
#(
    parameter int CLK_DIV    = 50,
    parameter int GAP_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       dataRdy,
    output logic       transEna,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy
);
    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    state_t state, state_n;
    logic [BYTE_BITS-1:0] sh, sh_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic mosi_n, ph_tc, gap_tc, ph_load, gap_load, timed_n;
    always_comb begin
        state_n   = state;
        sh_n      = sh;
        bit_cnt_n = bit_cnt;
        case (state)
            IDLE: if (dataRdy) begin
                state_n   = SETUP;
                sh_n      = data;
                bit_cnt_n = 3'(BYTE_BITS - 1);
            end
            SETUP: if (ph_tc) state_n = LOW;
            LOW:   if (ph_tc) state_n = HIGH;
            HIGH: if (ph_tc) begin
                state_n = bit_cnt == '0 ? HOLD : LOW;
                if (bit_cnt != '0) begin
                    bit_cnt_n = bit_cnt - 1'b1;
                    sh_n      = {sh[BYTE_BITS-2:0], 1'b0};
                end
            end
            HOLD: if (ph_tc) state_n = GAP_CYCLES > 0 ? GAP : DONE;
            GAP:  if (gap_tc) state_n = DONE;
            default: state_n = IDLE;
        endcase
    end
    // Each timed state reloads its counter on entry, so no counter ever wraps.
    assign timed_n  = state_n inside {SETUP, LOW, HIGH, HOLD};
    assign ph_load  = timed_n && state_n != state;
    assign gap_load = state_n == GAP && state != GAP;
    assign mosi_n   = (state == IDLE && state_n == SETUP) ? data[BYTE_BITS-1] :
                      (state_n == LOW && state != LOW)    ? sh_n[BYTE_BITS-1] : mosi;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh       <= '0;
            bit_cnt  <= '0;
            sclk     <= SCLK_IDLE;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            transEna <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            sh       <= sh_n;
            bit_cnt  <= bit_cnt_n;
            sclk     <= state_n == LOW ? ~SCLK_IDLE : SCLK_IDLE;
            cs_n     <= ~timed_n;
            mosi     <= mosi_n;
            transEna <= state_n == DONE;
            busy     <= state_n != IDLE;
        end
    end
    spi_phase_timer #(.W(DW)) u_phase (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ph_load),
        .load_val (DW'(CLK_DIV - 1)),
        .tc       (ph_tc)
    );
    spi_phase_timer #(.W(GW)) u_gap (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (gap_load),
        .load_val (GW'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0)),
        .tc       (gap_tc)
    );
endmodule

// File: tb/tb_spi_disp_tx.sv
// tb_spi_disp_tx: directed frame checks on two parameterisations of spi_disp_tx
module tb_spi_disp_tx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0] data = 8'h00;
    logic rdy = 1'b0;
    logic sel = 1'b0;
    logic rdy_a, rdy_b;
    logic te_a, sclk_a, mosi_a, cs_a, busy_a;
    logic te_b, sclk_b, mosi_b, cs_b, busy_b;
    logic te_w, sclk_w, mosi_w, cs_w, busy_w;
    int n_cmp = 0, n_bad = 0;
    int n_rise, first_rise, cs_rise, cs_fall2, te_cnt, te_t, frames, busy_gap, tog;
    logic [7:0] bytes [4];

    always #5 clk = ~clk;

    assign rdy_a  = rdy & ~sel;
    assign rdy_b  = rdy & sel;
    assign te_w   = sel ? te_b   : te_a;
    assign sclk_w = sel ? sclk_b : sclk_a;
    assign mosi_w = sel ? mosi_b : mosi_a;
    assign cs_w   = sel ? cs_b   : cs_a;
    assign busy_w = sel ? busy_b : busy_a;

    spi_disp_tx #(.CLK_DIV(2), .GAP_CYCLES(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .data(data), .dataRdy(rdy_a), .transEna(te_a),
        .sclk(sclk_a), .mosi(mosi_a), .cs_n(cs_a), .busy(busy_a)
    );
    spi_disp_tx #(.CLK_DIV(1), .GAP_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .data(data), .dataRdy(rdy_b), .transEna(te_b),
        .sclk(sclk_b), .mosi(mosi_b), .cs_n(cs_b), .busy(busy_b)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // First tick is E0 (dataRdy already driven); tick i is edge E0+i.
    task automatic watch(input int n, input int inj_on, input int inj_off, input logic [7:0] inj_d,
                         input bit reply, input logic [7:0] nxt);
        logic p_sclk, p_cs;
        logic [7:0] sr;
        int hold;
        n_rise = 0; first_rise = -1; cs_rise = -1; cs_fall2 = -1; te_cnt = 0; te_t = -1;
        frames = 0; busy_gap = 0; tog = 0; hold = 0; sr = 8'h00;
        p_sclk = sclk_w; p_cs = cs_w;
        for (int i = 0; i < n; i++) begin
            tick();
            if (i == 0) rdy = 1'b0;
            if (hold > 0) begin
                hold--;
                if (hold == 0) rdy = 1'b0;
            end
            if (i == inj_on) begin data = inj_d; rdy = 1'b1; end
            if (i == inj_off) rdy = 1'b0;
            if (sclk_w && !p_sclk) begin
                n_rise++;
                if (first_rise < 0) first_rise = i;
                sr = {sr[6:0], mosi_w};
            end
            if (sclk_w != p_sclk && i >= 1 && i <= 16) tog++;
            if (cs_w && !p_cs) begin
                if (frames < 4) bytes[frames] = sr;
                frames++;
                if (cs_rise < 0) cs_rise = i;
            end
            if (!cs_w && p_cs && i > 0 && cs_fall2 < 0) cs_fall2 = i;
            if (te_cnt == 0 && !busy_w) busy_gap++;
            if (te_w) begin
                te_cnt++;
                if (te_t < 0) te_t = i;
                if (reply && te_cnt == 1) begin data = nxt; rdy = 1'b1; hold = 2; end
            end
            p_sclk = sclk_w;
            p_cs = cs_w;
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_cs_n", cs_a, 1);
        chk("rst_sclk", sclk_a, 1);
        chk("rst_mosi", mosi_a, 0);
        chk("rst_te", te_a, 0);
        chk("rst_busy", busy_a, 0);
        rst_n = 1'b1;
        tick();

        data = 8'hA5; rdy = 1'b1;
        watch(45, -1, -1, 8'h00, 1'b0, 8'h00);
        chk("a5_byte", bytes[0], 8'hA5);
        chk("a5_rises", n_rise, 8);
        chk("a5_first_rise", first_rise, 4);
        chk("a5_cs_rise", cs_rise, 36);
        chk("a5_te_time", te_t, 40);
        chk("a5_te_count", te_cnt, 1);
        chk("a5_busy_after", busy_w, 0);

        data = 8'hFE; rdy = 1'b1;
        watch(90, -1, -1, 8'h00, 1'b1, 8'h01);
        chk("b2b_frames", frames, 2);
        chk("b2b_byte0", bytes[0], 8'hFE);
        chk("b2b_byte1", bytes[1], 8'h01);
        chk("b2b_te_count", te_cnt, 2);
        chk("b2b_cs_rise", cs_rise, 36);
        chk("b2b_cs_fall2", cs_fall2, 42);

        data = 8'h3C; rdy = 1'b1;
        watch(45, 2, 4, 8'h00, 1'b0, 8'h00);
        chk("busy_byte", bytes[0], 8'h3C);
        chk("busy_frames", frames, 1);
        chk("busy_te_count", te_cnt, 1);
        chk("busy_te_time", te_t, 40);
        chk("busy_gapless", busy_gap, 0);

        data = 8'hC3; rdy = 1'b1;
        watch(17, -1, -1, 8'h00, 1'b0, 8'h00);
        chk("mid_rises", n_rise, 4);
        rst_n = 1'b0;
        tick();
        chk("mid_cs_n", cs_a, 1);
        chk("mid_sclk", sclk_a, 1);
        chk("mid_mosi", mosi_a, 0);
        chk("mid_busy", busy_a, 0);
        rst_n = 1'b1;
        watch(50, -1, -1, 8'h00, 1'b0, 8'h00);
        chk("mid_no_te", te_cnt, 0);
        chk("mid_no_frame", frames, 0);
        data = 8'h5A; rdy = 1'b1;
        watch(45, -1, -1, 8'h00, 1'b0, 8'h00);
        chk("post_byte", bytes[0], 8'h5A);
        chk("post_frames", frames, 1);
        chk("post_te_time", te_t, 40);

        sel = 1'b1;
        chk("b_idle_cs_n", cs_w, 1);
        data = 8'h80; rdy = 1'b1;
        watch(22, -1, -1, 8'h00, 1'b0, 8'h00);
        chk("g0_byte", bytes[0], 8'h80);
        chk("g0_rises", n_rise, 8);
        chk("g0_first_rise", first_rise, 2);
        chk("g0_toggles", tog, 16);
        chk("g0_cs_rise", cs_rise, 18);
        chk("g0_te_time", te_t, 18);
        chk("g0_te_count", te_cnt, 1);
        chk("g0_busy_after", busy_w, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spi_disp_tx.md
Name: spi_disp_tx

Overview:
- Byte-wide SPI transmitter for the serial character display, downstream of the display controller state machine.
- Accepts one byte per `dataRdy` handshake and shifts it out MSB-first in SPI mode 3, one chip-select frame per byte.
- Enforces the display's inter-byte gap, then pulses `transEna` to request the next byte.

Parameters:
- CLK_DIV, 50, clk cycles per SCLK half-period (SCLK = f_clk/(2*CLK_DIV)); legal range is 1 or more.
- GAP_CYCLES, 5000, idle clk cycles after cs_n rises and before `transEna`; 0 is legal and means no gap.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset; synchronous, active-low. One clock; no other clock domain.
- data  in  8  byte to send; sampled only on the accepting edge.
- dataRdy  in  1  byte-valid; level-sampled in IDLE.
- transEna  out  1  one-cycle pulse: byte fully sent and gap elapsed; ready for the next byte.
- sclk  out  1  SPI clock; idles high.
- mosi  out  1  SPI data, MSB first.
- cs_n  out  1  display chip select, active low.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values while rst_n is low at a rising edge: state=IDLE, sclk=1, cs_n=1, mosi=0, transEna=0, busy=0, all counters 0.
- Reset mid-frame: the next edge forces the reset values, the partial byte is discarded, and no `transEna` is issued.
- Let E0 be the edge that samples dataRdy=1 while in IDLE.
- States:
  - IDLE: sclk=1, cs_n=1. On dataRdy=1, latch data into shift reg and go to SETUP.
  - SETUP: cs_n=0, mosi=data[7], sclk=1; lasts CLK_DIV cycles.
  - LOW: sclk=0; mosi takes the current bit at phase entry (this is the SCLK falling edge); lasts CLK_DIV cycles.
  - HIGH: sclk=1, mosi stable (the display samples on this rising edge); lasts CLK_DIV cycles. After HIGH, the bit count decrements. If bits remain, go to LOW; after bit 0, go to HOLD.
  - HOLD: sclk=1, cs_n=0; lasts CLK_DIV cycles, then cs_n=1.
  - GAP: cs_n=1; lasts GAP_CYCLES cycles; skipped entirely if GAP_CYCLES=0.
  - DONE: transEna=1 for exactly one cycle, then IDLE.
- Timing from E0:
  - cs_n falls at E0 and rises at E0+18*CLK_DIV.
  - transEna goes high at E0+18*CLK_DIV+GAP_CYCLES and low one edge later.
  - busy goes high at E0 and falls with the DONE→IDLE transition.
  - Exactly 8 sclk rising edges per frame, the first at E0+2*CLK_DIV.
- dataRdy is ignored in every state except IDLE, including the DONE cycle. A byte whose dataRdy overlaps the first IDLE cycle after DONE is accepted.
- `data` changing after E0 has no effect on the frame in progress.
- The controller samples `transEna` on its falling edge and drives `dataRdy` combinationally. The one-cycle `transEna` pulse spans one falling edge, so that handshake requires no extra logic here.
- Counter widths:
  - Divider: $clog2(CLK_DIV+1).
  - Gap: $clog2(GAP_CYCLES+1), minimum 1.
  - Bit counter: 3 bits, counting 7→0.
  - No wrap is ever reached: each counter is reloaded on every state entry.

Decomposition:
- Package spi_disp_pkg holds:
  - the state encoding localparams (IDLE, SETUP, LOW, HIGH, HOLD, GAP, DONE);
  - SCLK_IDLE=1 for mode 3;
  - BYTE_BITS=8.
- One sub-module, spi_phase_timer: a loadable down-counter with a terminal-count strobe. It is instantiated twice: once as the CLK_DIV phase timer and once as the GAP timer.
- The FSM, shift register and bit counter stay in spi_disp_tx.

Test Plan:
- Single byte: CLK_DIV=2, GAP_CYCLES=4, data=8'hA5 with a dataRdy pulse at E0. Required response: cs_n low E0..E0+36; mosi sampled at the 8 sclk rising edges = 1,0,1,0,0,1,0,1; transEna high exactly at E0+40 for one cycle.
- Back-to-back: a controller model replies to each transEna with the next byte (8'hFE, then 8'h01). Required response: two separate cs_n frames separated by at least 4 cycles plus IDLE; decoded bytes FE, 01; exactly 2 transEna pulses.
- dataRdy while busy: assert dataRdy with 8'h00 during LOW of a 8'h3C frame. Required response: the frame still decodes 3C; no second frame; busy continuous until DONE.
- Reset mid-frame: drop rst_n during the 4th HIGH phase. Required response: cs_n=1, sclk=1, mosi=0, busy=0 at the next edge; no transEna; the next byte after reset transmits cleanly.
- GAP_CYCLES=0, CLK_DIV=1, data=8'h80. Required response: transEna at E0+18; sclk toggles every cycle; mosi=1 only on the first bit.
